// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction ROM port plus the decode-side valid/ready and redirect signals.
// master = fetch unit, slave = ROM/decode environment.
interface instr_fetch_unit_if #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 10
);
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_req;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic [3:0]         opCode;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               instr_ready;
   logic               ni;
   logic [ADDR_W-1:0]  branch_target;
   logic               halted;

   modport master (
      output imem_addr, imem_req, instr, opCode, instr_pc, instr_valid, halted,
      input  imem_rdata, instr_ready, ni, branch_target
   );

   modport slave (
      input  imem_addr, imem_req, instr, opCode, instr_pc, instr_valid, halted,
      output imem_rdata, instr_ready, ni, branch_target
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, 1-cycle ROM read, 2-entry skid buffer toward controlUnit.
// Optional halt-opcode support is enabled with the FETCH_HALT_EN macro.
module instr_fetch_unit #(
   parameter int INSTR_W = 32,
   parameter int ADDR_W  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus
);
   // state | meaning
   // START | one idle cycle after reset release
   // RUN   | normal fetching
   // HALT  | halt word accepted, fetch stopped until reset (FETCH_HALT_EN only)
   typedef enum logic [1:0] {START, RUN, HALT} state_t;

   state_t             r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_req_addr;
   logic               r_inflight;
   logic [1:0]         r_count;
   logic [INSTR_W-1:0] r_buf_instr [2];
   logic [ADDR_W-1:0]  r_buf_pc    [2];

   logic       w_valid, w_redirect, w_pop, w_push, w_issue;
   logic       w_halt_pend, w_halt_pop;
   logic [2:0] w_level;

   assign w_valid    = (r_count != 2'd0);
   assign w_redirect = bus.ni && (r_state != HALT);
   assign w_pop      = w_valid && bus.instr_ready;
   assign w_push     = r_inflight && !w_redirect && !w_halt_pend;
   assign w_level    = {1'b0, r_count} + {2'b00, r_inflight};
   // Crediting the same-cycle pop is what lets the 2-entry buffer sustain 1 instr/cycle.
   assign w_issue    = (r_state == RUN) && !bus.ni && !w_halt_pend &&
                       (w_level < (3'd2 + {2'b00, w_pop}));

`ifdef FETCH_HALT_EN
   localparam logic [3:0] HALT_OP = 4'hF;
   logic r_halt_pend;

   assign w_halt_pend = r_halt_pend;
   assign w_halt_pop  = w_pop && !w_redirect && (r_buf_instr[0][INSTR_W-1 -: 4] == HALT_OP);
   assign bus.halted  = (r_state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_halt_pend <= 1'b0;
      else if (w_redirect)
         r_halt_pend <= 1'b0;
      else if (w_push && (bus.imem_rdata[INSTR_W-1 -: 4] == HALT_OP))
         r_halt_pend <= 1'b1;
   end
`else
   assign w_halt_pend = 1'b0;
   assign w_halt_pop  = 1'b0;
   assign bus.halted  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= START;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      bus.imem_req = 1'b0;
      case (r_state)
         START: w_state_nxt = RUN;
         RUN: begin
            bus.imem_req = w_issue;
            if (w_halt_pop)
               w_state_nxt = HALT;
         end
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = START;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc           <= '0;
         r_req_addr     <= '0;
         r_inflight     <= 1'b0;
         r_count        <= 2'd0;
         r_buf_instr[0] <= '0;
         r_buf_instr[1] <= '0;
         r_buf_pc[0]    <= '0;
         r_buf_pc[1]    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_req_addr <= r_pc;
            r_pc       <= r_pc + ADDR_W'(1);
         end else if (w_redirect) begin
            r_pc <= bus.branch_target;
         end

         if (w_redirect || (w_state_nxt == HALT)) begin
            r_count <= 2'd0;
         end else begin
            case ({w_push, w_pop})
               2'b10: begin
                  r_count <= r_count + 2'd1;
                  if (r_count == 2'd0) begin
                     r_buf_instr[0] <= bus.imem_rdata;
                     r_buf_pc[0]    <= r_req_addr;
                  end else begin
                     r_buf_instr[1] <= bus.imem_rdata;
                     r_buf_pc[1]    <= r_req_addr;
                  end
               end
               2'b01: begin
                  r_count        <= r_count - 2'd1;
                  r_buf_instr[0] <= r_buf_instr[1];
                  r_buf_pc[0]    <= r_buf_pc[1];
               end
               2'b11: begin
                  if (r_count == 2'd1) begin
                     r_buf_instr[0] <= bus.imem_rdata;
                     r_buf_pc[0]    <= r_req_addr;
                  end else begin
                     r_buf_instr[0] <= r_buf_instr[1];
                     r_buf_pc[0]    <= r_buf_pc[1];
                     r_buf_instr[1] <= bus.imem_rdata;
                     r_buf_pc[1]    <= r_req_addr;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.imem_addr   = r_pc;
   assign bus.instr       = r_buf_instr[0];
   assign bus.opCode      = r_buf_instr[0][INSTR_W-1 -: 4];
   assign bus.instr_pc    = r_buf_pc[0];
   assign bus.instr_valid = w_valid;

   // The issue rule keeps occupancy + inflight <= 2, so a push into a full buffer is a bug.
   assert property (@(posedge clk) disable iff (!rst_n) !(w_push && !w_pop && (r_count == 2'd2)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for startup/stall/redirect/wrap, randomized stream
// against a delivered-PC model, then async reset and halt-word sequence (both builds).
module tb_instr_fetch_unit;
   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 10;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam logic [INSTR_W-1:0] HALT_WORD = 32'hF000_0000;

   logic               clk    = 1'b0;
   logic               rst_n  = 1'b0;
   logic               ready  = 1'b0;
   logic               ni     = 1'b0;
   logic [ADDR_W-1:0]  target = '0;
   logic [INSTR_W-1:0] rom [DEPTH];
   logic [INSTR_W-1:0] rom_q  = '0;

   int vecs = 0;
   int errs = 0;
   int since;
   int exp_pc;
   logic exp_v, exp_h;
   logic [ADDR_W-1:0] exp_p;

   always #5 clk = ~clk;

   instr_fetch_unit_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

   assign bus.imem_rdata    = rom_q;
   assign bus.instr_ready   = ready;
   assign bus.ni            = ni;
   assign bus.branch_target = target;

   instr_fetch_unit #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   // Synchronous ROM: data one cycle after a request, garbage otherwise.
   always @(posedge clk)
      rom_q <= bus.imem_req ? rom[bus.imem_addr] : INSTR_W'($urandom);

   typedef struct {
      logic              rdy;
      logic              ni;
      logic [ADDR_W-1:0] tgt;
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic              vld;
      logic [ADDR_W-1:0] pc;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(logic rdy, logic n, int tgt, logic req, int addr, logic vld, int pc);
      vec_t r;
      r.rdy  = rdy;
      r.ni   = n;
      r.tgt  = ADDR_W'(tgt);
      r.req  = req;
      r.addr = ADDR_W'(addr);
      r.vld  = vld;
      r.pc   = ADDR_W'(pc);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_head(input string name, input logic [ADDR_W-1:0] pc);
      chk({name, "_pc"}, bus.instr_pc, pc);
      chk({name, "_instr"}, bus.instr, rom[pc]);
      chk({name, "_opcode"}, bus.opCode, rom[pc][INSTR_W-1 -: 4]);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++)
         rom[i] = {4'(i % 15), 28'(i * 32'h9E37_79B1)};

      //            rdy ni tgt    req addr  vld pc
      tbl.push_back(mk(1, 0, 0,     0, 0,    0, 0));     // 0  START
      tbl.push_back(mk(1, 0, 0,     1, 0,    0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 1,    0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 2,    1, 0));     // 3  first valid
      tbl.push_back(mk(1, 0, 0,     1, 3,    1, 1));
      tbl.push_back(mk(1, 0, 0,     1, 4,    1, 2));
      tbl.push_back(mk(1, 0, 0,     1, 5,    1, 3));
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 4));     // 7  stall 5 cycles
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 4));
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 4));
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 4));
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 4));
      tbl.push_back(mk(1, 0, 0,     1, 6,    1, 4));     // 12 resume
      tbl.push_back(mk(1, 0, 0,     1, 7,    1, 5));
      tbl.push_back(mk(1, 0, 0,     1, 8,    1, 6));
      tbl.push_back(mk(1, 1, 'h20,  0, 0,    1, 7));     // 15 redirect
      tbl.push_back(mk(1, 0, 0,     1, 'h20, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h21, 0, 0));
      tbl.push_back(mk(1, 1, 'h10,  0, 0,    1, 'h20));  // 18 back-to-back ni
      tbl.push_back(mk(1, 1, 'h30,  0, 0,    0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h30, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h31, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h32, 1, 'h30));
      tbl.push_back(mk(1, 0, 0,     1, 'h33, 1, 'h31));
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 'h32));  // 24 fill buffer
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 'h32));
      tbl.push_back(mk(0, 1, 'h40,  0, 0,    1, 'h32));  // 26 ni with 2 buffered
      tbl.push_back(mk(0, 0, 0,     1, 'h40, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h41, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h42, 1, 'h40));
      tbl.push_back(mk(1, 1, 1022,  0, 0,    1, 'h41));  // 30 wrap test
      tbl.push_back(mk(1, 0, 0,     1, 1022, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 1023, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 0,    1, 1022));
      tbl.push_back(mk(1, 0, 0,     1, 1,    1, 1023));
      tbl.push_back(mk(1, 0, 0,     1, 2,    1, 0));
      tbl.push_back(mk(1, 0, 0,     1, 3,    1, 1));
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 2));     // 37 halt word at 3 gets buffered
      tbl.push_back(mk(0, 0, 0,     0, 0,    1, 2));
      tbl.push_back(mk(0, 1, 'h50,  0, 0,    1, 2));     // 39 flushed before pop
      tbl.push_back(mk(1, 0, 0,     1, 'h50, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h51, 0, 0));
      tbl.push_back(mk(1, 0, 0,     1, 'h52, 1, 'h50));

      ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", bus.imem_req, 1'b0);
      chk("rst_addr", bus.imem_addr, '0);
      chk("rst_valid", bus.instr_valid, 1'b0);
      chk("rst_instr", bus.instr, '0);
      chk("rst_opcode", bus.opCode, '0);
      chk("rst_pc", bus.instr_pc, '0);
      chk("rst_halted", bus.halted, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         if (i == 30) rom[3] = HALT_WORD;
         ready  = tbl[i].rdy;
         ni     = tbl[i].ni;
         target = tbl[i].tgt;
         @(negedge clk);
         chk($sformatf("t%0d_req", i), bus.imem_req, tbl[i].req);
         if (tbl[i].req) chk($sformatf("t%0d_addr", i), bus.imem_addr, tbl[i].addr);
         chk($sformatf("t%0d_valid", i), bus.instr_valid, tbl[i].vld);
         if (tbl[i].vld) chk_head($sformatf("t%0d", i), tbl[i].pc);
         chk($sformatf("t%0d_halted", i), bus.halted, 1'b0);
         @(posedge clk);
         #1;
      end

      // Random stream: every accepted head must be the next PC of the current redirect run,
      // and valid must be up exactly from the 2nd edge after the last redirect onward.
      since  = -100;
      exp_pc = 0;
      for (int k = 0; k < 1500; k++) begin
         ready  = ($urandom_range(3) != 0);
         ni     = (k == 0) || ($urandom_range(15) == 0) || (exp_pc > 1000);
         target = ADDR_W'($urandom_range(900, 16));
         @(negedge clk);
         if (since >= 0) begin
            chk("rnd_valid", bus.instr_valid, since >= 2);
            if (since >= 2 && bus.instr_valid && ready) begin
               chk_head("rnd", ADDR_W'(exp_pc));
               exp_pc = (exp_pc + 1) % DEPTH;
            end
         end
         if (ni) begin
            chk("rnd_req_on_ni", bus.imem_req, 1'b0);
            exp_pc = int'(target);
            since  = -1;
         end
         @(posedge clk);
         since++;
         #1;
      end

      // Async reset mid-stream, then halt-word sequence from pc 0.
      ni    = 1'b0;
      ready = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.instr_valid, 1'b0);
      chk("arst_req", bus.imem_req, 1'b0);
      chk("arst_addr", bus.imem_addr, '0);
      chk("arst_pc", bus.instr_pc, '0);
      chk("arst_instr", bus.instr, '0);
      chk("arst_halted", bus.halted, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         ni     = (c == 8);
         target = ADDR_W'('h20);
         @(negedge clk);
`ifdef FETCH_HALT_EN
         exp_v = (c >= 3 && c <= 6);
         exp_p = ADDR_W'(c - 3);
         exp_h = (c >= 7);
         if (c >= 6) chk($sformatf("h%0d_req", c), bus.imem_req, 1'b0);
`else
         exp_v = (c >= 3 && c <= 8) || (c == 11);
         exp_p = (c == 11) ? ADDR_W'('h20) : ADDR_W'(c - 3);
         exp_h = 1'b0;
`endif
         chk($sformatf("h%0d_valid", c), bus.instr_valid, exp_v);
         if (exp_v) chk_head($sformatf("h%0d", c), exp_p);
         chk($sformatf("h%0d_halted", c), bus.halted, exp_h);
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
